// File: rtl/alu_pkg.sv
// Shared ALU definitions: function-code encoding used by the issue stage and the ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b100,
        ALU_XOR = 3'b101,
        ALU_INV = 3'b111
    } alu_func_e;

endpackage

// File: rtl/alu_issue_stage.sv
// Registered issue stage in front of the ALU: drops unassigned function codes and
// buffers up to two operations in a main/skid pair so in_ready stays registered.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_func,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output alu_func_e             out_func,
    output logic [DATA_WIDTH-1:0] out_a,
    output logic [DATA_WIDTH-1:0] out_b,
    output logic                  illegal_pulse,
    output logic [CNT_WIDTH-1:0]  illegal_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    alu_func_e             skid_func;
    logic [DATA_WIDTH-1:0] skid_a;
    logic [DATA_WIDTH-1:0] skid_b;
    logic                  accept;
    logic                  legal;
    logic                  acc_legal;
    logic                  issue;
    logic                  load_main_in;
    logic                  load_main_skid;
    logic                  load_skid;

    function automatic logic is_legal(input logic [2:0] f);
        return !((f == 3'b011) || (f == 3'b110));
    endfunction

    // INV only uses operand A; a zeroed B keeps the ALU input clean.
    function automatic logic [DATA_WIDTH-1:0] operand_b(input logic [2:0] f,
                                                        input logic [DATA_WIDTH-1:0] b);
        return (f == ALU_INV) ? '0 : b;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (c == '1) ? c : c + CNT_WIDTH'(1);
    endfunction

    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign legal     = is_legal(in_func);
    assign acc_legal = accept && legal;
    assign issue     = out_valid && out_ready;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (acc_legal) begin
                    state_nxt    = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (issue && acc_legal) begin
                    load_main_in = 1'b1;
                end else if (issue) begin
                    state_nxt = EMPTY;
                end else if (acc_legal) begin
                    state_nxt = TWO;
                    load_skid = 1'b1;
                end
            end
            TWO: begin
                if (issue) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Main register and control; an accept in a flush cycle is discarded but still counted if illegal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= EMPTY;
            in_ready      <= 1'b1;
            out_func      <= ALU_ADD;
            out_a         <= '0;
            out_b         <= '0;
            illegal_pulse <= 1'b0;
            illegal_count <= '0;
        end else begin
            illegal_pulse <= accept && !legal;
            if (accept && !legal) begin
                illegal_count <= sat_inc(illegal_count);
            end
            if (flush) begin
                state    <= EMPTY;
                in_ready <= 1'b1;
            end else begin
                state    <= state_nxt;
                in_ready <= (state_nxt != TWO);
                if (load_main_in) begin
                    out_func <= alu_func_e'(in_func);
                    out_a    <= in_a;
                    out_b    <= operand_b(in_func, in_b);
                end else if (load_main_skid) begin
                    out_func <= skid_func;
                    out_a    <= skid_a;
                    out_b    <= skid_b;
                end
            end
        end
    end

    // Skid contents are only meaningful in TWO, so they need no reset.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_func <= alu_func_e'(in_func);
            skid_a    <= in_a;
            skid_b    <= operand_b(in_func, in_b);
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: vector table, directed corner sequences and a queue scoreboard.
module tb_alu_issue_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [2:0] in_func = 3'b000;
    logic [7:0] in_a = 8'h00;
    logic [7:0] in_b = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic       illegal_pulse;
    logic [7:0] out_a;
    logic [7:0] out_b;
    logic [7:0] illegal_count;
    alu_pkg::alu_func_e out_func;

    alu_issue_stage #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_func(out_func),
        .out_a(out_a), .out_b(out_b),
        .illegal_pulse(illegal_pulse), .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct packed {
        logic [2:0] f;
        logic [7:0] a;
        logic [7:0] b;
    } op_t;

    function automatic bit legal_code(input logic [2:0] f);
        return !((f == 3'b011) || (f == 3'b110));
    endfunction

    function automatic op_t expect_op(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
        op_t o;
        o.f = f;
        o.a = a;
        o.b = (f == 3'b111) ? 8'h00 : b;
        return o;
    endfunction

    // Scoreboard model: queue occupancy predicts out_valid/in_ready; illegal accepts predict pulse/count.
    op_t q[$];
    op_t head;
    int  exp_cnt = 0;
    bit  exp_pulse = 1'b0;
    bit  m_rdy;
    bit  m_acc;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            exp_cnt   = 0;
            exp_pulse = 1'b0;
        end else begin
            m_rdy = (q.size() < 2);
            chk("mon_out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("mon_in_ready", 32'(in_ready), 32'(m_rdy));
            chk("mon_pulse", 32'(illegal_pulse), 32'(exp_pulse));
            chk("mon_count", 32'(illegal_count), 32'(exp_cnt));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("issue_without_expected_op", 32'(1), 32'(0));
                end else begin
                    head = q.pop_front();
                    chk("sb_func", 32'(out_func), 32'(head.f));
                    chk("sb_a", 32'(out_a), 32'(head.a));
                    chk("sb_b", 32'(out_b), 32'(head.b));
                end
            end
            m_acc = in_valid && m_rdy;
            if (flush) q.delete();
            else if (m_acc && legal_code(in_func)) q.push_back(expect_op(in_func, in_a, in_b));
            exp_pulse = m_acc && !legal_code(in_func);
            if (exp_pulse && exp_cnt < 255) exp_cnt++;
        end
    end

    typedef struct {
        logic [2:0] f;
        logic [7:0] a;
        logic [7:0] b;
        logic       ev;
        logic [7:0] eb;
        logic       ep;
    } vec_t;

    vec_t vec[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        in_func  = f;
        in_a     = a;
        in_b     = b;
    endtask

    initial begin
        vec[0] = '{3'b000, 8'h12, 8'h34, 1'b1, 8'h34, 1'b0};
        vec[1] = '{3'b001, 8'h50, 8'h0F, 1'b1, 8'h0F, 1'b0};
        vec[2] = '{3'b010, 8'hC3, 8'h3C, 1'b1, 8'h3C, 1'b0};
        vec[3] = '{3'b100, 8'h01, 8'h80, 1'b1, 8'h80, 1'b0};
        vec[4] = '{3'b101, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b0};
        vec[5] = '{3'b111, 8'hF0, 8'h77, 1'b1, 8'h00, 1'b0};
        vec[6] = '{3'b011, 8'h11, 8'h22, 1'b0, 8'h00, 1'b1};
        vec[7] = '{3'b110, 8'h33, 8'h44, 1'b0, 8'h00, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_out_func", 32'(out_func), 32'(0));
        chk("rst_out_a", 32'(out_a), 32'(0));
        chk("rst_out_b", 32'(out_b), 32'(0));
        chk("rst_pulse", 32'(illegal_pulse), 32'(0));
        chk("rst_count", 32'(illegal_count), 32'(0));
        rst_n = 1'b1;

        // Vector table, one op at a time with the ALU always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            drive(vec[i].f, vec[i].a, vec[i].b);
            step();
            in_valid = 1'b0;
            chk("tbl_valid", 32'(out_valid), 32'(vec[i].ev));
            if (vec[i].ev) begin
                chk("tbl_func", 32'(out_func), 32'(vec[i].f));
                chk("tbl_a", 32'(out_a), 32'(vec[i].a));
                chk("tbl_b", 32'(out_b), 32'(vec[i].eb));
            end
            chk("tbl_pulse", 32'(illegal_pulse), 32'(vec[i].ep));
        end
        step();

        // Back-to-back stream.
        drive(3'b000, 8'h12, 8'h34);
        step();
        chk("strm_add_a", 32'(out_a), 32'(8'h12));
        drive(3'b001, 8'h50, 8'h0F);
        step();
        in_valid = 1'b0;
        chk("strm_sub_func", 32'(out_func), 32'(3'b001));
        chk("strm_sub_a", 32'(out_a), 32'(8'h50));
        chk("strm_ready", 32'(in_ready), 32'(1));
        step();
        chk("strm_drain", 32'(out_valid), 32'(0));

        // Back-pressure into the skid register.
        out_ready = 1'b0;
        drive(3'b101, 8'hAA, 8'h55);
        step();
        chk("bp_ready1", 32'(in_ready), 32'(1));
        drive(3'b100, 8'h01, 8'h02);
        step();
        in_valid = 1'b0;
        chk("bp_ready0", 32'(in_ready), 32'(0));
        chk("bp_hold_a", 32'(out_a), 32'(8'hAA));
        step();
        chk("bp_stable_b", 32'(out_b), 32'(8'h55));
        out_ready = 1'b1;
        step();
        chk("bp_or_func", 32'(out_func), 32'(3'b100));
        chk("bp_or_a", 32'(out_a), 32'(8'h01));
        chk("bp_ready_back", 32'(in_ready), 32'(1));
        step();
        chk("bp_drain", 32'(out_valid), 32'(0));

        // Illegal codes around an INV.
        drive(3'b011, 8'h01, 8'h01);
        step();
        chk("ill_pulse1", 32'(illegal_pulse), 32'(1));
        chk("ill_novalid", 32'(out_valid), 32'(0));
        drive(3'b110, 8'h02, 8'h02);
        step();
        chk("ill_pulse2", 32'(illegal_pulse), 32'(1));
        drive(3'b111, 8'hF0, 8'h77);
        step();
        in_valid = 1'b0;
        chk("ill_pulse_end", 32'(illegal_pulse), 32'(0));
        chk("ill_count", 32'(illegal_count), 32'(4));
        chk("inv_func", 32'(out_func), 32'(3'b111));
        chk("inv_b_zero", 32'(out_b), 32'(0));
        step();

        // Saturate the illegal counter.
        for (int i = 0; i < 250; i++) begin
            drive(3'b011, 8'h00, 8'h00);
            step();
        end
        chk("sat_254", 32'(illegal_count), 32'(254));
        for (int i = 0; i < 3; i++) begin
            drive(3'b110, 8'h00, 8'h00);
            step();
            chk("sat_pulse", 32'(illegal_pulse), 32'(1));
            chk("sat_255", 32'(illegal_count), 32'(255));
        end
        in_valid = 1'b0;
        step();

        // Flush from TWO while the decoder offers an AND.
        out_ready = 1'b0;
        drive(3'b000, 8'h11, 8'h22);
        step();
        drive(3'b001, 8'h33, 8'h44);
        step();
        chk("fl_two", 32'(in_ready), 32'(0));
        drive(3'b010, 8'h0F, 8'hF0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", 32'(out_valid), 32'(0));
        chk("fl_ready", 32'(in_ready), 32'(1));
        out_ready = 1'b1;
        repeat (3) step();
        chk("fl_no_issue", 32'(out_valid), 32'(0));

        // Flush from ONE with a concurrent legal, then illegal, accept.
        out_ready = 1'b0;
        drive(3'b000, 8'h66, 8'h77);
        step();
        drive(3'b010, 8'h0F, 8'hF0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl1_valid", 32'(out_valid), 32'(0));
        drive(3'b000, 8'h66, 8'h77);
        step();
        drive(3'b110, 8'h00, 8'h00);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl1_ill_valid", 32'(out_valid), 32'(0));
        chk("fl1_ill_pulse", 32'(illegal_pulse), 32'(1));
        step();

        // Asynchronous reset while holding two ops.
        drive(3'b000, 8'h21, 8'h43);
        step();
        drive(3'b001, 8'h65, 8'h87);
        step();
        in_valid = 1'b0;
        chk("ar_two", 32'(in_ready), 32'(0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'(0));
        chk("ar_in_ready", 32'(in_ready), 32'(1));
        chk("ar_out_func", 32'(out_func), 32'(0));
        chk("ar_out_a", 32'(out_a), 32'(0));
        chk("ar_out_b", 32'(out_b), 32'(0));
        chk("ar_pulse", 32'(illegal_pulse), 32'(0));
        chk("ar_count", 32'(illegal_count), 32'(0));
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        drive(3'b000, 8'h5A, 8'hA5);
        step();
        in_valid = 1'b0;
        chk("ar_add_valid", 32'(out_valid), 32'(1));
        chk("ar_add_a", 32'(out_a), 32'(8'h5A));
        chk("ar_add_b", 32'(out_b), 32'(8'hA5));
        step();
        chk("ar_drain", 32'(out_valid), 32'(0));
        step();
        chk("sb_empty", 32'(q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
